// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 Hz timing constants, used by the sync generator and the
// pixel generator so both agree on display limits and sync windows.
package vga_timing_pkg;

    localparam int CLK_DIV   = 4;
    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam int HSYNC_START = H_DISPLAY + H_FRONT;
    localparam int HSYNC_END   = HSYNC_START + H_SYNC - 1;
    localparam int VSYNC_START = V_DISPLAY + V_FRONT;
    localparam int VSYNC_END   = VSYNC_START + V_SYNC - 1;

    localparam int COORD_W   = 10;
    localparam int COORD_MAX = 1 << COORD_W;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
        logic frame_tick;
    } sync_t;

    // Origin (0,0) is visible, so video_on comes out of reset high.
    localparam sync_t SYNC_RESET = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b1, frame_tick: 1'b0};

    function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_divider.sv
// Divides the system clock down to a one-clk pixel-rate strobe; reusable by any
// logic that must step once per pixel.
module pixel_tick_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick_o
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("pixel_tick_divider: CLK_DIV must be at least 1");
    end

    logic [CNT_W-1:0] count_q, count_d;
    logic             p_tick_q, p_tick_d;

    // The strobe is registered from the next count so it never glitches and
    // stays low during reset even when CLK_DIV is 1.
    always_comb begin
        count_d  = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
        p_tick_d = (count_d == LAST);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            p_tick_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            p_tick_q <= p_tick_d;
        end
    end

    assign p_tick_o = p_tick_q;

endmodule

// File: rtl/vga_sync_generator.sv
// VGA raster timing: pixel/line counters plus registered sync, video-active and
// frame strobes, all aligned to the same edge as the coordinates.
module vga_sync_generator #(
    parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV,
    parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic                               clk,
    input  logic                               reset,
    output logic                               p_tick,
    output logic [vga_timing_pkg::COORD_W-1:0] x,
    output logic [vga_timing_pkg::COORD_W-1:0] y,
    output logic                               video_on,
    output logic                               hsync,
    output logic                               vsync,
    output logic                               frame_tick
);

    import vga_timing_pkg::coord_t;
    import vga_timing_pkg::sync_t;
    import vga_timing_pkg::SYNC_RESET;
    import vga_timing_pkg::in_range;

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > vga_timing_pkg::COORD_MAX || V_TOTAL > vga_timing_pkg::COORD_MAX) begin : g_bad_timing
        $error("vga_sync_generator: H_TOTAL and V_TOTAL must fit the 10-bit counters");
    end

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
    localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic   tick;
    coord_t x_q, x_d;
    coord_t y_q, y_d;
    sync_t  sync_q, sync_d;

    pixel_tick_divider #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk     (clk),
        .reset   (reset),
        .p_tick_o(tick)
    );

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (tick) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + coord_t'(1);
            end else begin
                x_d = x_q + coord_t'(1);
            end
        end

        // Decoded from the next coordinates so the registered flags switch on
        // the same edge as x/y; vsync follows y and is therefore line-aligned.
        sync_d.hsync      = !in_range(x_d, HS_START, HS_END);
        sync_d.vsync      = !in_range(y_d, VS_START, VS_END);
        sync_d.video_on   = (x_d < H_VIS) && (y_d < V_VIS);
        sync_d.frame_tick = tick && (x_q == H_LAST) && (y_q == V_LAST);
    end

    // NOTE: all control state, including the output flags, takes the
    // asynchronous reset so a mid-frame reset clears the raster immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q    <= '0;
            y_q    <= '0;
            sync_q <= SYNC_RESET;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            sync_q <= sync_d;
        end
    end

    assign p_tick     = tick;
    assign x          = x_q;
    assign y          = y_q;
    assign video_on   = sync_q.video_on;
    assign hsync      = sync_q.hsync;
    assign vsync      = sync_q.vsync;
    assign frame_tick = sync_q.frame_tick;

endmodule
